// File: rtl/vreg_access_sequencer_pkg.sv
// Shared vector-register types: crossbar request format, access kinds and the
// per-port access sequencer state set.
package vreg_access_sequencer_pkg;

  localparam int unsigned NUM_OF_VECTOR_REG = 32;
  localparam int unsigned VECTOR_REG_DEPTH  = 64;
  localparam int unsigned VECTOR_REG_WIDTH  = 64;

  localparam int unsigned VREG_PTR_W = $clog2(NUM_OF_VECTOR_REG);
  localparam int unsigned VREG_AW    = $clog2(VECTOR_REG_DEPTH);

  typedef enum logic {
    READ_REQ  = 1'b0,
    WRITE_REQ = 1'b1
  } access_type_t;

  typedef struct packed {
    logic                        vld;
    logic [VREG_PTR_W-1:0]       vec_reg_ptr;
    logic [VREG_AW-1:0]          addr;
    access_type_t                access_type;
    logic [VREG_AW:0]            access_length;
    logic [VECTOR_REG_WIDTH-1:0] data;
  } cntrl_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/vreg_access_sequencer.sv
// Per-port sequencer: expands one vector-register access command into single-element
// crossbar requests and tracks outstanding responses. Define VREG_SEQ_TIMEOUT_EN for a stall timeout.
module vreg_access_sequencer
  import vreg_access_sequencer_pkg::*;
#(
  parameter int unsigned NUM_OF_VECTOR_REG = vreg_access_sequencer_pkg::NUM_OF_VECTOR_REG,
  parameter int unsigned VECTOR_REG_DEPTH  = vreg_access_sequencer_pkg::VECTOR_REG_DEPTH,
  parameter int unsigned VECTOR_REG_WIDTH  = vreg_access_sequencer_pkg::VECTOR_REG_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES    = 255
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 cmd_vld,
  output logic                                 cmd_rdy,
  input  logic [$clog2(NUM_OF_VECTOR_REG)-1:0] cmd_reg_ptr,
  input  logic [$clog2(VECTOR_REG_DEPTH)-1:0]  cmd_base_addr,
  input  logic [$clog2(VECTOR_REG_DEPTH):0]    cmd_length,
  input  access_type_t                         cmd_access_type,
  input  logic [VECTOR_REG_WIDTH-1:0]          wr_data,
  input  logic                                 wr_data_vld,
  output logic                                 wr_data_rdy,
  output cntrl_req_t                           req,
  input  logic                                 req_grant,
  input  logic                                 rsp_vld,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 error
);

  localparam int unsigned AW = $clog2(VECTOR_REG_DEPTH);
  localparam int unsigned PW = $clog2(NUM_OF_VECTOR_REG);
  localparam logic [AW-1:0] LAST_ADDR = AW'(VECTOR_REG_DEPTH - 1);
  localparam logic [AW:0]   ONE_LEFT  = 1;

  seq_state_t   state_q;
  logic [PW-1:0] ptr_q;
  access_type_t acc_q;
  logic [AW-1:0] addr_q;
  logic [AW:0]   rem_q;
  logic [AW:0]   outstanding_q;

  logic req_vld;
  logic accept;
  logic rsp_take;
  logic timeout_hit;

  assign req_vld  = (state_q == ISSUE) && ((acc_q == READ_REQ) || wr_data_vld);
  assign accept   = req_vld && req_grant;
  // Responses with nothing outstanding (e.g. left over from before a reset) are dropped.
  assign rsp_take = rsp_vld && (outstanding_q != '0);

`ifdef VREG_SEQ_TIMEOUT_EN
  localparam int unsigned SW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SW-1:0] stall_q;
  logic          stall_now;
  logic          error_q;

  assign stall_now   = ((state_q == ISSUE) && req_vld && !req_grant) ||
                       ((state_q == DRAIN) && !rsp_vld && (outstanding_q != '0));
  assign timeout_hit = stall_now && (stall_q == SW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      error_q <= 1'b0;
    end else begin
      if (!stall_now || timeout_hit) begin
        stall_q <= '0;
      end else begin
        stall_q <= stall_q + 1'b1;
      end
      if (timeout_hit) begin
        error_q <= 1'b1;
      end else if ((state_q == IDLE) && cmd_vld) begin
        error_q <= 1'b0;
      end
    end
  end

  assign error = error_q;
`else
  assign timeout_hit = 1'b0;
  assign error       = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      acc_q   <= READ_REQ;
      addr_q  <= '0;
      rem_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_vld) begin
            ptr_q   <= cmd_reg_ptr;
            acc_q   <= cmd_access_type;
            addr_q  <= cmd_base_addr;
            rem_q   <= cmd_length;
            state_q <= (cmd_length == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (timeout_hit) begin
            state_q <= DONE;
          end else if (accept) begin
            addr_q <= (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
            rem_q  <= rem_q - 1'b1;
            if (rem_q == ONE_LEFT) begin
              state_q <= DRAIN;
            end
          end
        end
        // Exit on the settled count, so the last response is absorbed before done.
        DRAIN: begin
          if ((outstanding_q == '0) || timeout_hit) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding_q <= '0;
    end else if (timeout_hit) begin
      outstanding_q <= '0;
    end else if (accept && !rsp_take) begin
      outstanding_q <= outstanding_q + 1'b1;
    end else if (!accept && rsp_take) begin
      outstanding_q <= outstanding_q - 1'b1;
    end
  end

  always_comb begin
    req = '0;
    if (state_q == ISSUE) begin
      req.vld           = req_vld;
      req.vec_reg_ptr   = ptr_q;
      req.addr          = addr_q;
      req.access_type   = acc_q;
      req.access_length = rem_q;
      req.data          = wr_data;
    end
  end

  assign cmd_rdy     = (state_q == IDLE) && !reset;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign wr_data_rdy = accept && (acc_q == WRITE_REQ);

endmodule

// File: tb/tb_vreg_access_sequencer.sv
// Self-checking bench for vreg_access_sequencer: directed scenarios plus randomized
// commands checked against an element-index model of the request stream.
module tb_vreg_access_sequencer;
  import vreg_access_sequencer_pkg::*;

  localparam int DEPTH = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_vld;
  logic         cmd_rdy;
  logic [4:0]   cmd_reg_ptr;
  logic [5:0]   cmd_base_addr;
  logic [6:0]   cmd_length;
  access_type_t cmd_access_type;
  logic [63:0]  wr_data;
  logic         wr_data_vld;
  logic         wr_data_rdy;
  cntrl_req_t   req;
  logic         req_grant;
  logic         rsp_vld;
  logic         busy;
  logic         done;
  logic         error;

  int checks   = 0;
  int failures = 0;

  vreg_access_sequencer #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_vld        (cmd_vld),
    .cmd_rdy        (cmd_rdy),
    .cmd_reg_ptr    (cmd_reg_ptr),
    .cmd_base_addr  (cmd_base_addr),
    .cmd_length     (cmd_length),
    .cmd_access_type(cmd_access_type),
    .wr_data        (wr_data),
    .wr_data_vld    (wr_data_vld),
    .wr_data_rdy    (wr_data_rdy),
    .req            (req),
    .req_grant      (req_grant),
    .rsp_vld        (rsp_vld),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle();
    chk("idle_cmd_rdy", cmd_rdy, 1'b1);
    chk("idle_busy", busy, 1'b0);
    chk("idle_done", done, 1'b0);
    chk("idle_req", req, '0);
  endtask

  // gmode: 0 grant always, 1 random grant (at most 3 misses in a row), 2 withheld on cycles 1-3
  // wmode: 0 write data always valid, 1 invalid on cycle 2 only, 2 random
  task automatic run_cmd(input int len, input int base, input int ptr, input bit wr,
                         input int gmode, input int wmode);
    int   k;
    int   last_g;
    int   miss;
    bit   finished;
    bit   g;
    bit   wv;
    bit   exp_vld;
    logic [63:0] wd;
    int   rspq[$];

    @(negedge clk);
    cmd_vld         = 1'b1;
    cmd_reg_ptr     = 5'(ptr);
    cmd_base_addr   = 6'(base);
    cmd_length      = 7'(len);
    cmd_access_type = wr ? WRITE_REQ : READ_REQ;
    req_grant       = 1'b0;
    wr_data_vld     = 1'b0;
    rsp_vld         = 1'b0;
    #1;
    chk("accept_cmd_rdy", cmd_rdy, 1'b1);
    chk("accept_busy", busy, 1'b0);

    k        = 0;
    last_g   = -3;
    miss     = 0;
    finished = 1'b0;
    for (int c = 1; c < 400; c++) begin
      @(negedge clk);
      cmd_vld = 1'b0;
      case (gmode)
        0:       g = 1'b1;
        1:       g = (miss >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
        default: g = (c > 3);
      endcase
      case (wmode)
        0:       wv = 1'b1;
        1:       wv = (c != 2);
        default: wv = ($urandom_range(0, 3) != 0);
      endcase
      wd          = {$urandom, $urandom};
      req_grant   = g;
      wr_data_vld = wv;
      wr_data     = wd;
      rsp_vld     = 1'b0;
      if (rspq.size() > 0 && rspq[0] == c) begin
        rsp_vld = 1'b1;
        void'(rspq.pop_front());
      end
      #1;
      chk("busy", busy, 1'b1);
      chk("cmd_rdy_busy", cmd_rdy, 1'b0);
      chk("error", error, 1'b0);
      if (k < len) begin
        exp_vld = wr ? wv : 1'b1;
        chk("req_vld", req.vld, exp_vld);
        chk("done_early", done, 1'b0);
        chk("wr_data_rdy", wr_data_rdy, wr && wv && g);
        if (exp_vld) begin
          chk("req_addr", req.addr, (base + k) % DEPTH);
          chk("req_len", req.access_length, len - k);
          chk("req_ptr", req.vec_reg_ptr, ptr);
          chk("req_type", req.access_type, wr ? WRITE_REQ : READ_REQ);
          if (wr) chk("req_data", req.data, wd);
          if (g) begin
            rspq.push_back(c + 2);
            last_g = c;
            k++;
            miss = 0;
          end else begin
            miss++;
          end
        end
      end else begin
        chk("req_vld_after", req.vld, 1'b0);
        chk("wr_data_rdy_after", wr_data_rdy, 1'b0);
        chk("done", done, c == last_g + 4);
        if (c >= last_g + 4) begin
          finished = 1'b1;
          break;
        end
      end
    end
    chk("cmd_complete", finished, 1'b1);

    @(negedge clk);
    req_grant   = 1'b0;
    wr_data_vld = 1'b0;
    rsp_vld     = 1'b0;
    #1;
    chk_idle();
    chk("idle_error", error, 1'b0);
  endtask

  initial begin
    reset           = 1'b1;
    cmd_vld         = 1'b0;
    cmd_reg_ptr     = '0;
    cmd_base_addr   = '0;
    cmd_length      = '0;
    cmd_access_type = READ_REQ;
    wr_data         = '0;
    wr_data_vld     = 1'b0;
    req_grant       = 1'b0;
    rsp_vld         = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cmd_rdy", cmd_rdy, 1'b0);
    chk("rst_req", req, '0);
    chk("rst_wr_data_rdy", wr_data_rdy, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_idle();

    // Directed scenarios
    run_cmd(4, 10, 3, 1'b0, 0, 0);
    run_cmd(4, 62, 9, 1'b1, 0, 1);
    run_cmd(4, 20, 5, 1'b0, 2, 0);
    run_cmd(0, 33, 1, 1'b0, 0, 0);
    run_cmd(1, 63, 31, 1'b1, 0, 0);
    run_cmd(64, 0, 2, 1'b0, 0, 0);

    // Reset in the middle of ISSUE after two grants
    @(negedge clk);
    cmd_vld         = 1'b1;
    cmd_reg_ptr     = 5'd7;
    cmd_base_addr   = 6'd5;
    cmd_length      = 7'd6;
    cmd_access_type = READ_REQ;
    @(negedge clk);
    cmd_vld   = 1'b0;
    req_grant = 1'b1;
    @(negedge clk);
    @(negedge clk);
    req_grant = 1'b0;
    #1;
    chk("mid_addr", req.addr, 7);
    chk("mid_len", req.access_length, 4);
    reset = 1'b1;
    #1;
    chk("mid_rst_req", req, '0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_cmd_rdy", cmd_rdy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_wr_data_rdy", wr_data_rdy, 1'b0);
    @(negedge clk);
    reset   = 1'b0;
    rsp_vld = 1'b1;
    #1;
    chk_idle();
    @(negedge clk);
    #1;
    chk_idle();
    @(negedge clk);
    rsp_vld = 1'b0;
    run_cmd(3, 20, 1, 1'b0, 0, 0);

`ifdef VREG_SEQ_TIMEOUT_EN
    // Grant never given: done with error after 8 stall cycles, error sticky until next accept
    @(negedge clk);
    cmd_vld         = 1'b1;
    cmd_reg_ptr     = 5'd2;
    cmd_base_addr   = 6'd40;
    cmd_length      = 7'd3;
    cmd_access_type = READ_REQ;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      cmd_vld   = 1'b0;
      req_grant = 1'b0;
      #1;
      chk("to_req_vld", req.vld, 1'b1);
      chk("to_req_addr", req.addr, 40);
      chk("to_done", done, 1'b0);
      chk("to_error_early", error, 1'b0);
    end
    @(negedge clk);
    #1;
    chk("to_req_drop", req.vld, 1'b0);
    chk("to_done_pulse", done, 1'b1);
    chk("to_error", error, 1'b1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      chk_idle();
      chk("to_error_sticky", error, 1'b1);
    end
    run_cmd(2, 0, 0, 1'b0, 0, 0);
`endif

    // Randomized commands
    for (int i = 0; i < 12; i++) begin
      run_cmd(int'($urandom_range(0, 64)), int'($urandom_range(0, 63)),
              int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1, 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
